// File: rtl/row_pair_packer_pkg.sv
// Shared types and conversion helper for the row DWT 9/7 front end.
// ROW_PAIR_PACKER_DC_SHIFT_EN selects unsigned input with DC level shift.
package row_pair_packer_pkg;

  localparam int DEF_DATA_W = 16;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] odd;
    logic [DEF_DATA_W-1:0] even;
  } pair_t;

  // Pixel to fixed point: optional level shift, sign extend, align.
  // Result is masked to dw bits; caller takes the low dw bits.
  function automatic logic [63:0] to_fixed(
    input logic [63:0] p,
    input int          pw,
    input int          sh,
    input int          dw
  );
    logic [63:0] msk;
    logic [63:0] v;
    msk = (64'd1 << pw) - 64'd1;
    v   = p & msk;
`ifdef ROW_PAIR_PACKER_DC_SHIFT_EN
    v = v - (64'd1 << (pw - 1));
`else
    if (((v >> (pw - 1)) & 64'd1) != 64'd0) begin
      v = v | ~msk;
    end
`endif
    v = v << sh;
    v = v & ((64'd1 << dw) - 64'd1);
    return v;
  endfunction

endpackage

// File: rtl/row_pair_packer.sv
// Packs raster pixels into {odd, even} pairs for the row DWT 9/7.
// ROW_PAIR_PACKER_DC_SHIFT_EN: input unsigned, level shift applied.
module row_pair_packer
  import row_pair_packer_pkg::*;
#(
  parameter int PixelWidth      = 8,
  parameter int DataWidth       = 16,
  parameter int InShift         = 6,
  parameter int MaximumSideSize = 512
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [PixelWidth-1:0]  s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);

  localparam int CW = $clog2(MaximumSideSize) + 1;

  if (PixelWidth + InShift > DataWidth) begin : g_width_chk
    $error("PixelWidth+InShift exceeds DataWidth");
  end

  state_t                 state, state_n;
  logic [DataWidth-1:0]   held, held_n;
  logic [DataWidth-1:0]   mirror, mirror_n;
  logic                   pair_sof, pair_sof_n;
  logic [CW-1:0]          col, col_n;
  logic [CW-1:0]          col_base, col_inc;
  logic                   valid_n, sof_n, eol_n;
  logic [2*DataWidth-1:0] data_n;
  logic [DataWidth-1:0]   conv;
  logic                   in_fire;
  logic                   even_slot;

  assign s_ready_o = !m_valid_o | m_ready_i;
  assign in_fire   = s_valid_i & s_ready_o;
  assign even_slot = (state == EVEN) | s_sof_i;

  assign conv = DataWidth'(to_fixed(
    64'(s_data_i), PixelWidth, InShift, DataWidth));

  // Next state, pair assembly and output register load.
  always_comb begin
    state_n    = state;
    held_n     = held;
    mirror_n   = mirror;
    pair_sof_n = pair_sof;
    col_n      = col;
    valid_n    = m_valid_o & ~m_ready_i;
    data_n     = m_data_o;
    sof_n      = m_sof_o;
    eol_n      = m_eol_o;
    col_base   = s_sof_i ? '0 : col;
    col_inc    = (col_base == CW'(MaximumSideSize))
               ? col_base : col_base + 1'b1;
    if (in_fire) begin
      if (even_slot) begin
        if (s_eol_i) begin
          valid_n = 1'b1;
          data_n  = {(col_base == '0) ? conv : mirror,
                     conv};
          sof_n   = s_sof_i;
          eol_n   = 1'b1;
          state_n = EVEN;
          col_n   = '0;
        end else begin
          held_n     = conv;
          pair_sof_n = s_sof_i;
          state_n    = ODD;
          col_n      = col_inc;
        end
      end else begin
        valid_n  = 1'b1;
        data_n   = {conv, held};
        sof_n    = pair_sof;
        eol_n    = s_eol_i;
        mirror_n = conv;
        state_n  = EVEN;
        col_n    = s_eol_i ? '0 : col_inc;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= EVEN;
      held      <= '0;
      mirror    <= '0;
      pair_sof  <= 1'b0;
      col       <= '0;
      m_valid_o <= 1'b0;
      m_sof_o   <= 1'b0;
      m_eol_o   <= 1'b0;
      m_data_o  <= '0;
    end else begin
      state     <= state_n;
      held      <= held_n;
      mirror    <= mirror_n;
      pair_sof  <= pair_sof_n;
      col       <= col_n;
      m_valid_o <= valid_n;
      m_sof_o   <= sof_n;
      m_eol_o   <= eol_n;
      m_data_o  <= data_n;
    end
  end

  a_col_bound : assert property (
    @(posedge clk_i) disable iff (rst_i)
    col <= CW'(MaximumSideSize));

  a_hold : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (m_valid_o && !m_ready_i) |=>
    (m_valid_o && $stable(m_data_o) &&
     $stable(m_sof_o) && $stable(m_eol_o)));

endmodule

// File: tb/tb_row_pair_packer.sv
// Directed bench for row_pair_packer.
// Vectors are written as unsigned pixels; pix() maps to signed input.
module tb_row_pair_packer;
  import row_pair_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_ready;
  logic        s_valid;
  logic        s_sof;
  logic        s_eol;
  logic [7:0]  s_data;
  logic        m_ready;
  logic        m_valid;
  logic        m_sof;
  logic        m_eol;
  logic [31:0] m_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  row_pair_packer dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_ready_o (s_ready),
    .s_valid_i (s_valid),
    .s_sof_i   (s_sof),
    .s_eol_i   (s_eol),
    .s_data_i  (s_data),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_sof_o   (m_sof),
    .m_eol_o   (m_eol),
    .m_data_o  (m_data)
  );

  function automatic logic [7:0] pix(input logic [7:0] u);
`ifdef ROW_PAIR_PACKER_DC_SHIFT_EN
    return u;
`else
    return u ^ 8'h80;
`endif
  endfunction

  function automatic pair_t mk(input logic [15:0] o,
                               input logic [15:0] e);
    pair_t r;
    r.odd  = o;
    r.even = e;
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] p,
                      input logic sof,
                      input logic eol);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = p;
    s_sof   = sof;
    s_eol   = eol;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_sof", 32'(m_sof), 32'd0);
    chk("rst_eol", 32'(m_eol), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // even row 128..131
    send(pix(8'd128), 1'b1, 1'b0);
    chk("r1_hold", 32'(m_valid), 32'd0);
    send(pix(8'd129), 1'b0, 1'b0);
    chk("r1_v1", 32'(m_valid), 32'd1);
    chk("r1_d1", m_data, mk(16'h0040, 16'h0000));
    chk("r1_sof1", 32'(m_sof), 32'd1);
    chk("r1_eol1", 32'(m_eol), 32'd0);
    send(pix(8'd130), 1'b0, 1'b0);
    chk("r1_gap", 32'(m_valid), 32'd0);
    send(pix(8'd131), 1'b0, 1'b1);
    chk("r1_v2", 32'(m_valid), 32'd1);
    chk("r1_d2", m_data, mk(16'h00C0, 16'h0080));
    chk("r1_sof2", 32'(m_sof), 32'd0);
    chk("r1_eol2", 32'(m_eol), 32'd1);

    // odd row 0,255,10 with mirror
    send(pix(8'd0), 1'b1, 1'b0);
    send(pix(8'd255), 1'b0, 1'b0);
    chk("r2_d1", m_data, mk(16'h1FC0, 16'hE000));
    chk("r2_sof1", 32'(m_sof), 32'd1);
    chk("r2_eol1", 32'(m_eol), 32'd0);
    send(pix(8'd10), 1'b0, 1'b1);
    chk("r2_v2", 32'(m_valid), 32'd1);
    chk("r2_d2", m_data, mk(16'h1FC0, 16'hE280));
    chk("r2_sof2", 32'(m_sof), 32'd0);
    chk("r2_eol2", 32'(m_eol), 32'd1);

    // single pixel row
    send(pix(8'd128), 1'b1, 1'b1);
    chk("r3_v", 32'(m_valid), 32'd1);
    chk("r3_d", m_data, 32'h0000_0000);
    chk("r3_sof", 32'(m_sof), 32'd1);
    chk("r3_eol", 32'(m_eol), 32'd1);

    // back-pressure with a pair pending
    send(pix(8'd1), 1'b1, 1'b0);
    m_ready = 1'b0;
    send(pix(8'd2), 1'b0, 1'b0);
    chk("bp_v0", 32'(m_valid), 32'd1);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = pix(8'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(m_valid), 32'd1);
      chk("bp_data", m_data, mk(16'hE080, 16'hE040));
      chk("bp_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("bp_drain", 32'(m_valid), 32'd0);
    send(pix(8'd4), 1'b0, 1'b1);
    chk("bp_d2", m_data, mk(16'hE100, 16'hE0C0));
    chk("bp_eol2", 32'(m_eol), 32'd1);
    chk("bp_sof2", 32'(m_sof), 32'd0);
    @(posedge clk);
    #1;
    chk("bp_nodup", 32'(m_valid), 32'd0);

    // sof restart while holding an even sample
    send(pix(8'd5), 1'b1, 1'b0);
    send(pix(8'd6), 1'b1, 1'b0);
    chk("rs_none", 32'(m_valid), 32'd0);
    send(pix(8'd7), 1'b0, 1'b1);
    chk("rs_v", 32'(m_valid), 32'd1);
    chk("rs_d", m_data, mk(16'hE1C0, 16'hE180));
    chk("rs_sof", 32'(m_sof), 32'd1);
    chk("rs_eol", 32'(m_eol), 32'd1);

    // async reset while output valid
    send(pix(8'd20), 1'b1, 1'b0);
    send(pix(8'd21), 1'b0, 1'b0);
    chk("ar_pre", 32'(m_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(m_valid), 32'd0);
    chk("ar_data", m_data, 32'h0);
    rst = 1'b0;

    // async reset while holding an even sample
    send(pix(8'd40), 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    send(pix(8'd22), 1'b0, 1'b0);
    chk("ar_even", 32'(m_valid), 32'd0);
    send(pix(8'd23), 1'b0, 1'b1);
    chk("ar_v", 32'(m_valid), 32'd1);
    chk("ar_d", m_data, mk(16'hE5C0, 16'hE580));
    chk("ar_sof", 32'(m_sof), 32'd0);
    chk("ar_eol", 32'(m_eol), 32'd1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
